// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by a 1 Hz tick, with a valid/ready set port.
// Optional alarm compare (alarm_time / alarm_hit) is built when TOD_ALARM_EN is defined.
module time_of_day_counter #(
  parameter int HOUR_WRAP = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        run,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [23:0] set_time,
  output logic        set_err,
  output logic [23:0] time_bcd,
  output logic        sec_pulse,
  output logic        day_wrap
`ifdef TOD_ALARM_EN
  ,
  input  logic [23:0] alarm_time,
  output logic        alarm_hit
`endif
);

  // state   | meaning
  // STOPPED | time held, ticks ignored, set accepted
  // RUNNING | ticks advance time, set accepted
  // LOADING | captured set value validated and applied; ticks discarded

  if (HOUR_WRAP != 24 && HOUR_WRAP != 12) begin : g_bad_hour_wrap
    $error("time_of_day_counter: HOUR_WRAP must be 24 or 12");
  end

  localparam logic [7:0] HOUR_MAX = (HOUR_WRAP == 12) ? 8'h11 : 8'h23;
  localparam logic [7:0] HOUR_LIM = (HOUR_WRAP == 12) ? 8'd12 : 8'd24;

  typedef enum logic [1:0] {STOPPED, RUNNING, LOADING} state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic [23:0] cap_q, cap_d;
  logic [23:0] time_q, time_d;
  logic        err_q, err_d;
  logic        sec_q, sec_d;
  logic        wrap_q, wrap_d;
  logic [23:0] next_time;
  logic        inc;
  logic        hs;

  function automatic logic [23:0] tod_inc(input logic [23:0] t);
    logic [3:0] ht, ho, mt, mo, st, so;
    {ht, ho, mt, mo, st, so} = t;
    if (so != 4'd9) so = so + 4'd1;
    else begin
      so = 4'd0;
      if (st != 4'd5) st = st + 4'd1;
      else begin
        st = 4'd0;
        if (mo != 4'd9) mo = mo + 4'd1;
        else begin
          mo = 4'd0;
          if (mt != 4'd5) mt = mt + 4'd1;
          else begin
            mt = 4'd0;
            if ({ht, ho} == HOUR_MAX) {ht, ho} = 8'h00;
            else if (ho != 4'd9) ho = ho + 4'd1;
            else begin
              ho = 4'd0;
              ht = ht + 4'd1;
            end
          end
        end
      end
    end
    return {ht, ho, mt, mo, st, so};
  endfunction

  function automatic logic tod_valid(input logic [23:0] t);
    logic       ok;
    logic [7:0] hval;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (t[7:4] > 4'd5 || t[15:12] > 4'd5) ok = 1'b0;
    hval = {4'd0, t[23:20]} * 8'd10 + {4'd0, t[19:16]};
    if (hval >= HOUR_LIM) ok = 1'b0;
    return ok;
  endfunction

  assign set_ready = ready_q && (state_q != LOADING);
  assign hs        = set_valid && set_ready;
  assign next_time = tod_inc(time_q);

  always_comb begin
    state_d = state_q;
    ready_d = 1'b1;
    cap_d   = cap_q;
    time_d  = time_q;
    err_d   = 1'b0;
    sec_d   = 1'b0;
    wrap_d  = 1'b0;
    inc     = 1'b0;
    case (state_q)
      LOADING: begin
        if (tod_valid(cap_q)) time_d = cap_q;
        else                  err_d  = 1'b1;
        state_d = run ? RUNNING : STOPPED;
      end
      default: begin
        // a set request wins over a coincident tick; that second is lost
        if (hs) begin
          cap_d   = set_time;
          state_d = LOADING;
        end else begin
          inc     = (state_q == RUNNING) && run && tick;
          state_d = run ? RUNNING : STOPPED;
        end
      end
    endcase
    if (inc) begin
      time_d = next_time;
      sec_d  = 1'b1;
      wrap_d = (next_time == 24'h000000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      ready_q <= 1'b0;
      cap_q   <= 24'h000000;
      time_q  <= 24'h000000;
      err_q   <= 1'b0;
      sec_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cap_q   <= cap_d;
      time_q  <= time_d;
      err_q   <= err_d;
      sec_q   <= sec_d;
      wrap_q  <= wrap_d;
    end
  end

  assign time_bcd  = time_q;
  assign set_err   = err_q;
  assign sec_pulse = sec_q;
  assign day_wrap  = wrap_q;

`ifdef TOD_ALARM_EN
  logic hit_q, hit_d;

  // only tick-driven increments can fire; a set load never does
  assign hit_d = inc && (next_time == alarm_time);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= 1'b0;
    else        hit_q <= hit_d;
  end

  assign alarm_hit = hit_q;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Testbench for time_of_day_counter: 24-hour and 12-hour instances driven in parallel,
// checked against a seconds-of-day reference model plus directed vector table.
module tb_time_of_day_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick, run, set_valid;
  logic [23:0] set_time;
  logic [1:0]  rdy, err, sec, wrap;
  logic [23:0] tm0, tm1;
`ifdef TOD_ALARM_EN
  logic [23:0] alarm_time;
  logic [1:0]  hit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_of_day_counter #(.HOUR_WRAP(24)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .set_valid(set_valid),
    .set_ready(rdy[0]), .set_time(set_time), .set_err(err[0]), .time_bcd(tm0),
    .sec_pulse(sec[0]), .day_wrap(wrap[0])
`ifdef TOD_ALARM_EN
    , .alarm_time(alarm_time), .alarm_hit(hit[0])
`endif
  );

  time_of_day_counter #(.HOUR_WRAP(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .set_valid(set_valid),
    .set_ready(rdy[1]), .set_time(set_time), .set_err(err[1]), .time_bcd(tm1),
    .sec_pulse(sec[1]), .day_wrap(wrap[1])
`ifdef TOD_ALARM_EN
    , .alarm_time(alarm_time), .alarm_hit(hit[1])
`endif
  );

  // reference model: time kept as seconds since midnight
  int          hw [2] = '{24, 12};
  int          m_secs [2];
  bit          m_load [2];
  bit          m_run [2];
  logic [23:0] m_cap [2];
  bit          m_ready;
  bit          e_err [2];
  bit          e_sec [2];
  bit          e_wrap [2];
  bit          e_hit [2];

  function automatic logic [23:0] to_bcd(int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int digit(logic [23:0] t, int k);
    logic [23:0] v;
    v = t >> (4 * k);
    return int'(v[3:0]);
  endfunction

  function automatic bit tod_ok(logic [23:0] t, int hwv);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 6; k++) if (digit(t, k) > 9) ok = 1'b0;
    if (digit(t, 1) > 5 || digit(t, 3) > 5) ok = 1'b0;
    if (digit(t, 5) * 10 + digit(t, 4) >= hwv) ok = 1'b0;
    return ok;
  endfunction

  function automatic int from_bcd(logic [23:0] t);
    return (digit(t, 5) * 10 + digit(t, 4)) * 3600 + (digit(t, 3) * 10 + digit(t, 2)) * 60
           + digit(t, 1) * 10 + digit(t, 0);
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_secs[i] = 0; m_load[i] = 1'b0; m_run[i] = 1'b0; m_cap[i] = 24'h0;
      e_err[i] = 1'b0; e_sec[i] = 1'b0; e_wrap[i] = 1'b0; e_hit[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit hs;
    hs = set_valid && m_ready;
    for (int i = 0; i < 2; i++) begin
      e_err[i] = 1'b0; e_sec[i] = 1'b0; e_wrap[i] = 1'b0; e_hit[i] = 1'b0;
      if (m_load[i]) begin
        if (tod_ok(m_cap[i], hw[i])) m_secs[i] = from_bcd(m_cap[i]);
        else                         e_err[i] = 1'b1;
        m_load[i] = 1'b0;
        m_run[i]  = run;
      end else if (hs) begin
        m_load[i] = 1'b1;
        m_cap[i]  = set_time;
      end else begin
        if (m_run[i] && run && tick) begin
          m_secs[i] = (m_secs[i] + 1) % (hw[i] * 3600);
          e_sec[i]  = 1'b1;
          e_wrap[i] = (m_secs[i] == 0);
`ifdef TOD_ALARM_EN
          e_hit[i]  = (to_bcd(m_secs[i]) == alarm_time);
`endif
        end
        m_run[i] = run;
      end
    end
    m_ready = !m_load[0];
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk24(string name, logic [23:0] act, logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk24("time24", tm0, to_bcd(m_secs[0]));
    chk24("time12", tm1, to_bcd(m_secs[1]));
    chk1("ready24", rdy[0], m_ready);
    chk1("ready12", rdy[1], m_ready);
    chk1("err24", err[0], e_err[0]);
    chk1("err12", err[1], e_err[1]);
    chk1("sec24", sec[0], e_sec[0]);
    chk1("sec12", sec[1], e_sec[1]);
    chk1("wrap24", wrap[0], e_wrap[0]);
    chk1("wrap12", wrap[1], e_wrap[1]);
`ifdef TOD_ALARM_EN
    chk1("hit24", hit[0], e_hit[0]);
    chk1("hit12", hit[1], e_hit[1]);
`endif
  endtask

  task automatic cyc(input bit t, input bit r, input bit v, input logic [23:0] st);
    @(negedge clk);
    tick = t; run = r; set_valid = v; set_time = st;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    bit          t, r, v;
    logic [23:0] st;
    logic [23:0] et;
    bit          es, ew, ee, er;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [23:0] st;
    int          r;

    rst_n = 1'b0; tick = 1'b0; run = 1'b0; set_valid = 1'b0; set_time = 24'h0;
`ifdef TOD_ALARM_EN
    alarm_time = 24'h999999;
`endif
    model_reset();
    #12;
    chk24("reset_time", tm0, 24'h000000);
    chk1("reset_ready", rdy[0], 1'b0);
    chk1("reset_err", err[0], 1'b0);
    chk1("reset_sec", sec[0], 1'b0);
    chk1("reset_wrap", wrap[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 24'h0);
    chk1("ready_after_release", rdy[0], 1'b1);

    // directed vectors, expectations for the 24-hour instance
    vecs.push_back('{0, 1, 0, 24'h0, 24'h000000, 0, 0, 0, 1});
    for (int i = 1; i <= 5; i++) vecs.push_back('{1, 1, 0, 24'h0, 24'(i), 1, 0, 0, 1});
    vecs.push_back('{1, 1, 1, 24'h235958, 24'h000005, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 24'h0, 24'h235958, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 0, 24'h0, 24'h235959, 1, 0, 0, 1});
    vecs.push_back('{1, 1, 0, 24'h0, 24'h000000, 1, 1, 0, 1});
    vecs.push_back('{0, 1, 0, 24'h0, 24'h000000, 0, 0, 0, 1});
    vecs.push_back('{0, 1, 1, 24'h006000, 24'h000000, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 24'h0, 24'h000000, 0, 0, 1, 1});
    vecs.push_back('{0, 1, 0, 24'h0, 24'h000000, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 1, 24'h120000, 24'h000000, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 24'h0, 24'h120000, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 0, 24'h0, 24'h120000, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 0, 24'h0, 24'h120000, 0, 0, 0, 1});
    vecs.push_back('{0, 1, 0, 24'h0, 24'h120000, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 0, 24'h0, 24'h120001, 1, 0, 0, 1});

    foreach (vecs[n]) begin
      cyc(vecs[n].t, vecs[n].r, vecs[n].v, vecs[n].st);
      chk24($sformatf("vec%0d_time", n), tm0, vecs[n].et);
      chk1($sformatf("vec%0d_sec", n), sec[0], vecs[n].es);
      chk1($sformatf("vec%0d_wrap", n), wrap[0], vecs[n].ew);
      chk1($sformatf("vec%0d_err", n), err[0], vecs[n].ee);
      chk1($sformatf("vec%0d_ready", n), rdy[0], vecs[n].er);
    end

    // 12-hour wrap 11:59:59 -> 00:00:00
    cyc(0, 1, 1, 24'h115959);
    cyc(0, 1, 0, 24'h0);
    chk24("h12_loaded", tm1, 24'h115959);
    cyc(1, 1, 0, 24'h0);
    chk24("h12_wrap_time", tm1, 24'h000000);
    chk1("h12_wrap_pulse", wrap[1], 1'b1);
    chk24("h24_no_wrap_time", tm0, 24'h120000);
    cyc(0, 1, 0, 24'h0);
    chk1("h12_wrap_one_cycle", wrap[1], 1'b0);

    // reset while LOADING drops the captured value
    cyc(0, 1, 1, 24'h101010);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk24("rst_load_time", tm0, 24'h000000);
    chk1("rst_load_ready", rdy[0], 1'b0);
    chk1("rst_load_err", err[0], 1'b0);
    @(posedge clk);
    #1;
    chk24("rst_hold_time", tm0, 24'h000000);
    chk1("rst_hold_err", err[0], 1'b0);
    chk1("rst_hold_err12", err[1], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 24'h0);
    chk1("rst_release_ready", rdy[0], 1'b1);
    chk24("rst_release_time", tm0, 24'h000000);

`ifdef TOD_ALARM_EN
    alarm_time = 24'h000003;
    cyc(0, 1, 0, 24'h0);
    cyc(1, 1, 0, 24'h0);
    chk1("alarm_tick1", hit[0], 1'b0);
    cyc(1, 1, 0, 24'h0);
    chk1("alarm_tick2", hit[0], 1'b0);
    cyc(1, 1, 0, 24'h0);
    chk1("alarm_tick3", hit[0], 1'b1);
    chk1("alarm_tick3_sec", sec[0], 1'b1);
    cyc(0, 1, 1, 24'h000003);
    cyc(0, 1, 0, 24'h0);
    chk24("alarm_load_time", tm0, 24'h000003);
    chk1("alarm_load_nohit", hit[0], 1'b0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       st = 24'($urandom);
        1:       st = to_bcd(int'($urandom_range(43190, 43199)));
        2:       st = to_bcd(int'($urandom_range(86390, 86399)));
        default: st = to_bcd(int'($urandom_range(0, 86399)));
      endcase
`ifdef TOD_ALARM_EN
      if ($urandom_range(0, 63) == 0) alarm_time = to_bcd(int'($urandom_range(0, 86399)));
`endif
      cyc(1'($urandom), $urandom_range(0, 99) < 90, $urandom_range(0, 15) == 0, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
